lshifter_pipe: RTL and testbench

Pipelined left shifter and rotator: the left-direction counterpart of the team's combinational right shifter. It is built as a barrel of `shift_len` registered stages, with valid/ready handshakes on both sides. It accepts one operand per cycle and sits between a producer and a consumer that may stall. Data inside the pipeline is never lost or reordered.

---
 rtl/lshifter_pipe_if.sv | 24 ++
 rtl/lshifter_pipe.sv | 110 +++++++++++
 tb/tb_lshifter_pipe.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lshifter_pipe_if.sv
// Valid/ready bundle for lshifter_pipe: operand side in, result side out.
interface lshifter_pipe_if #(
    parameter int data_width = 8,
    parameter int shift_len  = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] data_in;
    logic [shift_len-1:0]  bits;
    logic                  rotate;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] data_out;

    modport master (
        output in_valid, data_in, bits, rotate, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, bits, rotate, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/lshifter_pipe.sv
// lshifter_pipe: left shift/rotate barrel of shift_len registered stages
// with valid/ready flow control on both sides.
module lshifter_pipe #(
    parameter int data_width = 8,
    parameter int shift_len  = 3
) (
    input logic            clk,
    input logic            rst_n,
    lshifter_pipe_if.slave io
);
    localparam int CW_RAW = shift_len * (shift_len - 1) / 2;
    localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;
    localparam int RW     = (shift_len > 1) ? shift_len - 1 : 1;

    logic [shift_len-1:0]  valid_q, valid_d;
    logic [RW-1:0]         rot_q, rot_d;
    logic [data_width-1:0] data_q [shift_len];
    logic [data_width-1:0] data_d [shift_len];
    logic [CW-1:0]         carry_q, carry_d, carry_en;
    logic [shift_len-1:0]  ready;

    // Stage k keeps only the shift bits still to be applied, packed
    // back to back; the last stage needs no control beyond its valid.
    for (genvar k = 0; k < shift_len; k++) begin : g_st
        localparam int AMT = 1 << k;
        localparam int ROT = AMT % data_width;
        localparam int W   = shift_len - 1 - k;
        localparam int OFF = k * (shift_len - 1) - k * (k - 1) / 2;

        logic                  up_b;
        logic                  up_r;
        logic [data_width-1:0] up_d, up_sh, up_rl;

        if (k == 0) begin : g_head
            assign valid_d[k] = io.in_valid;
            assign up_r       = io.rotate;
            assign up_d       = io.data_in;
            assign up_b       = io.bits[0];
        end else begin : g_body
            assign valid_d[k] = valid_q[k-1];
            assign up_r       = rot_q[k-1];
            assign up_d       = data_q[k-1];
            assign up_b       = carry_q[OFF-W-1];
        end

        if (W > 0) begin : g_carry
            if (k == 0) begin : g_src_in
                assign carry_d[OFF+:W] = io.bits[shift_len-1:1];
            end else begin : g_src_st
                assign carry_d[OFF+:W] = carry_q[OFF-W+:W];
            end
            assign carry_en[OFF+:W] = {W{ready[k]}};
            assign rot_d[k]         = up_r;
        end

        assign up_sh     = up_d << AMT;
        assign up_rl     = (up_d << ROT) | (up_d >> (data_width - ROT));
        assign data_d[k] = !up_b ? up_d : (up_r ? up_rl : up_sh);
    end

    if (CW_RAW == 0) begin : g_single
        assign carry_d  = '0;
        assign carry_en = '0;
        assign rot_d    = '0;
    end

    // Unrolled ready chain: a stage can load unless it and every stage
    // downstream of it is full while the consumer stalls.
    always_comb begin
        logic ready_acc;
        ready     = '0;
        ready_acc = io.out_ready;
        for (int k = shift_len - 1; k >= 0; k--) begin
            ready_acc = !valid_q[k] || ready_acc;
            ready[k]  = ready_acc;
        end
    end

    assign io.in_ready  = ready[0];
    assign io.out_valid = valid_q[shift_len-1];
    assign io.data_out  = data_q[shift_len-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rot_q   <= '0;
            carry_q <= '0;
            for (int k = 0; k < shift_len; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < shift_len; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_d[k];
                    data_q[k]  <= data_d[k];
                end
            end
            for (int k = 0; k < shift_len - 1; k++) begin
                if (ready[k]) begin
                    rot_q[k] <= rot_d[k];
                end
            end
            for (int i = 0; i < CW; i++) begin
                if (carry_en[i]) begin
                    carry_q[i] <= carry_d[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_lshifter_pipe.sv
// Scoreboard bench for lshifter_pipe: directed operands push expected
// results; a negedge monitor pops and compares each transfer.
module tb_lshifter_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [7:0] data;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] bp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] bp_e [4] = '{8'h44, 8'h88, 8'hCC, 8'h11};

    lshifter_pipe_if #(.data_width(8), .shift_len(3)) io ();

    lshifter_pipe #(.data_width(8), .shift_len(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && io.out_valid && io.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got 0x%0h want none",
                         io.data_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", io.data_out, e.data);
                if (e.lat) check("latency", cyc - e.acc, 3);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] b,
                        input logic r, input logic [7:0] e,
                        input bit lat, output int waits);
        waits = 0;
        @(posedge clk);
        #1;
        io.in_valid = 1'b1;
        io.data_in  = d;
        io.bits     = b;
        io.rotate   = r;
        @(negedge clk);
        while (!io.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!io.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else begin
            exp_q.push_back('{data: e, acc: cyc, lat: lat});
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.data_in  = 8'h5A;
        io.bits     = 3'd5;
        io.rotate   = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w;
        int         n;
        logic [7:0] held;

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.data_in   = '0;
        io.bits      = '0;
        io.rotate    = 1'b0;
        io.out_ready = 1'b1;
        held         = '0;
        #3;
        check("rst_out_valid", io.out_valid, 0);
        check("rst_data_out", io.data_out, 0);
        check("rst_in_ready", io.in_ready, 1);
        #20 rst_n = 1'b1;

        send(8'hB3, 3'd3, 1'b0, 8'h98, 1'b1, w); drain();
        send(8'hB3, 3'd3, 1'b1, 8'h9D, 1'b1, w); drain();
        send(8'h81, 3'd7, 1'b1, 8'hC0, 1'b1, w); drain();
        send(8'hB3, 3'd0, 1'b0, 8'hB3, 1'b1, w); drain();
        send(8'hB3, 3'd0, 1'b1, 8'hB3, 1'b1, w); drain();
        send(8'h01, 3'd7, 1'b0, 8'h80, 1'b1, w); drain();
        send(8'hFE, 3'd7, 1'b0, 8'h00, 1'b1, w); drain();

        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 3'd1, 1'b0, 8'(i << 1), 1'b1, w);
            check("stream_in_ready", w, 0);
        end
        drain();

        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            io.out_ready = 1'b0;
            io.in_valid  = 1'b1;
            io.data_in   = bp_d[(n < 4) ? n : 3];
            io.bits      = 3'd2;
            io.rotate    = 1'b1;
            @(negedge clk);
            if (c >= 3) begin
                check("bp_in_ready", io.in_ready, 0);
                check("bp_out_valid", io.out_valid, 1);
                if (c == 3) begin
                    held = io.data_out;
                    check("bp_head", io.data_out, 8'h44);
                end else begin
                    check("bp_stable", io.data_out, held);
                end
            end
            if (io.in_ready && n < 4) begin
                exp_q.push_back('{data: bp_e[n], acc: cyc, lat: 1'b0});
                n++;
            end
        end
        check("bp_accepted", n, 3);
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_ready", io.in_ready, 1);
        if (io.in_ready && n < 4) begin
            exp_q.push_back('{data: bp_e[n], acc: cyc, lat: 1'b0});
            n++;
        end
        drain();
        check("bp_total", n, 4);

        send(8'h55, 3'd1, 1'b0, 8'hAA, 1'b0, w);
        send(8'h66, 3'd2, 1'b1, 8'h99, 1'b0, w);
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        io.in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", io.out_valid, 0);
        check("mid_rst_data_out", io.data_out, 0);
        check("mid_rst_in_ready", io.in_ready, 1);
        @(posedge clk);
        #1;
        check("mid_rst_hold_valid", io.out_valid, 0);
        #2 rst_n = 1'b1;
        send(8'h0F, 3'd4, 1'b1, 8'hF0, 1'b1, w);
        drain();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
